match_result_accum: RTL and testbench
=====================================

MATCH_RESULT_ACCUM -- requirements
Module: match_result_accum

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, width of one string-index entry in str_table.
REQ-002 SHALL have parameter NUM, default 4, weight slots per group.
REQ-003 SHALL have parameter GROUPS, default 4, group count; SLOTS = NUM*GROUPS (localparam).
REQ-004 SHALL have parameter STRINGS, default 100, number of tracked strings; CW = clog2(STRINGS+1) (localparam).
REQ-005 SHALL have port clk input 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset input 1, synchronous active-high reset.
REQ-007 SHALL have port start input 1, opens a new match window.
REQ-008 SHALL have port match_mode input 1, 0=AND (all mapped slots must match), 1=OR (any slot); sampled only with accepted start.
REQ-009 SHALL have port beat_valid input 1, router_output/str_table/slot_en valid this cycle.
REQ-010 SHALL have port beat_last input 1, qualifies final beat of window.
REQ-011 SHALL have port router_output input SLOTS, per-slot match bit.
REQ-012 SHALL have port str_table input DWIDTH*SLOTS, slot i string index at bits [DWIDTH*i +: DWIDTH].
REQ-013 SHALL have port slot_en input SLOTS, per-slot enable mask.
REQ-014 SHALL have port result_ready input 1, consumer accepts result.
REQ-015 SHALL have port result_valid output 1, result bundle valid.
REQ-016 SHALL have port string_results output STRINGS, per-string matched flag.
REQ-017 SHALL have port match_count output CW, number of ones in string_results.
REQ-018 SHALL have port index_error output 1, sticky flag: enabled slot mapped index >= STRINGS during window.
REQ-019 SHALL have port busy output 1, high in ACCUM or REPORT.

Function
REQ-020 SHALL implement FSM IDLE -> ACCUM (start) -> REPORT (accepted beat with beat_last) -> IDLE (result_valid & result_ready).
REQ-021 SHALL on accepted start: latch match_mode; flags = all 1 (AND) or all 0 (OR); touched = 0; index_error = 0.
REQ-022 SHALL accept a beat only in ACCUM with beat_valid high; beats in IDLE/REPORT ignored.
REQ-023 SHALL for each accepted beat, each slot i with slot_en[i]=1 and index k<STRINGS: AND mode flag[k] &= router_output[i], OR mode flag[k] |= router_output[i]; touched[k]=1.
REQ-024 SHALL combine multiple slots mapping to the same k within one beat in mode order (AND of all, OR of any), independent of slot ordering.
REQ-025 SHALL ignore enabled slots with k>=STRINGS and set index_error; disabled slots never set it.
REQ-026 SHALL drive string_results = flags & touched (untouched strings never report matched).
REQ-027 SHALL assert result_valid the cycle after the beat_last beat is accepted, with that beat included; match_count consistent with string_results same cycle.
REQ-028 SHALL hold string_results, match_count, index_error stable while result_valid=1 and result_ready=0.
REQ-029 SHALL treat start during ACCUM as restart (REQ-021), discarding partial window; start during REPORT ignored.
REQ-030 SHALL, on beat_valid and start in same ACCUM cycle, apply restart and discard the beat.
REQ-031 SHALL accept start in the cycle after REPORT handshake (IDLE); start in handshake cycle itself ignored.
REQ-032 SHALL drive string_results=0 and match_count=0 whenever result_valid=0.

Reset
REQ-033 SHALL on reset: state IDLE, result_valid=0, busy=0, string_results=0, match_count=0, index_error=0, flags=0, touched=0, latched mode=AND.
REQ-034 SHALL let reset override all inputs in the same cycle, including mid-window and mid-REPORT (result dropped).

Structure
REQ-035 SHALL place FSM state encoding and match_mode encodings in shared package match_pkg.
REQ-036 SHALL use one sub-module popcount (parameter W, output clog2(W+1) bits) for match_count.

Verification
REQ-037 SHALL test AND: start mode0; beat_last, slot_en=0x0003, slots0,1 -> k=5, router=0b11 -> next cycle result_valid, string_results bit5 only, match_count=1.
REQ-038 SHALL test AND fail: as REQ-037 with router=0b01 -> string_results=0, match_count=0.
REQ-039 SHALL test OR multi-beat: mode1; beat0 slot0->k=2 router0=0; beat1(last) slot3->k=2 router3=1 -> bit2=1, match_count=1.
REQ-040 SHALL test index error: slot0->k=120 enabled, last -> index_error=1, string_results=0; same with slot_en=0 -> index_error=0.
REQ-041 SHALL test backpressure/restart: result_ready=0 five cycles -> outputs stable; start mid-ACCUM discards earlier beats.
REQ-042 SHALL test reset asserted during REPORT -> next cycle result_valid=0, busy=0, outputs zero.

Source files
------------

// File: rtl/match_pkg.sv
// Shared encodings for the match result accumulator.
// FSM states and match-mode values used across the block.
package match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef enum logic {
    MODE_AND = 1'b0,
    MODE_OR  = 1'b1
  } mode_t;

endpackage

// File: rtl/match_result_accum_popcount.sv
// Population count of a W-bit vector.
// Output is wide enough to hold W itself.
module popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++)
      count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/match_result_accum.sv
// Accumulates per-slot match bits into per-string flags over a window
// of beats, then presents the result bundle with a valid/ready handshake.
module match_result_accum
  import match_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int NUM     = 4,
  parameter int GROUPS  = 4,
  parameter int STRINGS = 100
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            match_mode,
  input  logic                            beat_valid,
  input  logic                            beat_last,
  input  logic [NUM*GROUPS-1:0]           router_output,
  input  logic [DWIDTH*NUM*GROUPS-1:0]    str_table,
  input  logic [NUM*GROUPS-1:0]           slot_en,
  input  logic                            result_ready,
  output logic                            result_valid,
  output logic [STRINGS-1:0]              string_results,
  output logic [$clog2(STRINGS+1)-1:0]    match_count,
  output logic                            index_error,
  output logic                            busy
);

  localparam int SLOTS = NUM * GROUPS;
  localparam int CW    = $clog2(STRINGS + 1);

  state_t             state;
  mode_t              mode;
  logic [STRINGS-1:0] flags;
  logic [STRINGS-1:0] touched;
  logic [STRINGS-1:0] flags_nx;
  logic [STRINGS-1:0] touched_nx;
  logic               err_nx;

  function automatic logic [31:0] slot_idx(
    input logic [DWIDTH*SLOTS-1:0] tab,
    input int                      i
  );
    return 32'(tab[DWIDTH*i +: DWIDTH]);
  endfunction

  // Folding slot by slot keeps same-string hits order independent.
  always_comb begin
    flags_nx   = flags;
    touched_nx = touched;
    err_nx     = index_error;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_en[i]) begin
        if (slot_idx(str_table, i) >= 32'(STRINGS)) begin
          err_nx = 1'b1;
        end else begin
          for (int k = 0; k < STRINGS; k++) begin
            if (slot_idx(str_table, i) == 32'(k)) begin
              touched_nx[k] = 1'b1;
              if (mode == MODE_OR)
                flags_nx[k] = flags_nx[k] | router_output[i];
              else
                flags_nx[k] = flags_nx[k] & router_output[i];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode         <= MODE_AND;
      flags        <= '0;
      touched      <= '0;
      index_error  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_ACCUM;
            mode        <= mode_t'(match_mode);
            flags       <= match_mode ? '0 : '1;
            touched     <= '0;
            index_error <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (start) begin
            mode        <= mode_t'(match_mode);
            flags       <= match_mode ? '0 : '1;
            touched     <= '0;
            index_error <= 1'b0;
          end else if (beat_valid) begin
            flags       <= flags_nx;
            touched     <= touched_nx;
            index_error <= err_nx;
            if (beat_last) begin
              state        <= ST_REPORT;
              result_valid <= 1'b1;
            end
          end
        end
        ST_REPORT: begin
          if (result_ready) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = (state != ST_IDLE);
  assign string_results = result_valid ? (flags & touched) : '0;

  popcount #(
    .W (STRINGS)
  ) u_popcount (
    .bits  (string_results),
    .count (match_count)
  );

endmodule

// File: tb/tb_match_result_accum.sv
// Self-checking bench for match_result_accum: vector table plus
// hand-written multi-cycle sequences, results checked via a scoreboard.
module tb_match_result_accum;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          match_mode;
  logic          beat_valid;
  logic          beat_last;
  logic [15:0]   router_output;
  logic [127:0]  str_table;
  logic [15:0]   slot_en;
  logic          result_ready;
  logic          result_valid;
  logic [99:0]   string_results;
  logic [6:0]    match_count;
  logic          index_error;
  logic          busy;

  match_result_accum dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .match_mode     (match_mode),
    .beat_valid     (beat_valid),
    .beat_last      (beat_last),
    .router_output  (router_output),
    .str_table      (str_table),
    .slot_en        (slot_en),
    .result_ready   (result_ready),
    .result_valid   (result_valid),
    .string_results (string_results),
    .match_count    (match_count),
    .index_error    (index_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [15:0]  en;
    logic [127:0] tab;
    logic [15:0]  rt;
    logic [99:0]  res;
    int           cnt;
    logic         err;
  } vec_t;

  typedef struct {
    logic [99:0] res;
    int          cnt;
    logic        err;
  } exp_t;

  exp_t q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] tab,
                                       input int slot, input int val);
    logic [127:0] t;
    t = tab;
    t[8*slot +: 8] = 8'(val);
    return t;
  endfunction

  function automatic logic [99:0] bit_at(input int k);
    logic [99:0] b;
    b = '0;
    b[k] = 1'b1;
    return b;
  endfunction

  task automatic idle_inputs();
    start = 0; match_mode = 0; beat_valid = 0; beat_last = 0;
    router_output = '0; str_table = '0; slot_en = '0;
    result_ready = 0;
  endtask

  task automatic drive_beat(input logic last, input logic [15:0] en,
                            input logic [127:0] tab, input logic [15:0] rt);
    beat_valid = 1; beat_last = last;
    slot_en = en; str_table = tab; router_output = rt;
  endtask

  // Waits for result_valid, pops the expected bundle and compares.
  task automatic wait_result(input string name, output exp_t e);
    int cyc;
    cyc = 0;
    e.res = '0; e.cnt = 0; e.err = 0;
    while (!result_valid && cyc < 20) begin
      step();
      cyc++;
    end
    if (!result_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: result_valid never rose", name);
      return;
    end
    chk({name, " latency"}, 128'(cyc), 128'(0));
    if (q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: result with empty scoreboard", name);
      return;
    end
    e = q.pop_front();
    chk({name, " res"}, 128'(string_results), 128'(e.res));
    chk({name, " cnt"}, 128'(match_count), 128'(e.cnt));
    chk({name, " err"}, 128'(index_error), 128'(e.err));
    chk({name, " busy"}, 128'(busy), 128'(1));
  endtask

  task automatic handshake(input string name);
    result_ready = 1;
    step();
    result_ready = 0;
    chk({name, " valid drop"}, 128'(result_valid), 128'(0));
    chk({name, " idle busy"}, 128'(busy), 128'(0));
    chk({name, " res zero"}, 128'(string_results), 128'(0));
  endtask

  task automatic open_window(input logic mode);
    start = 1; match_mode = mode;
    step();
    start = 0; match_mode = 0;
  endtask

  task automatic push_exp(input logic [99:0] res, input int cnt,
                          input logic err);
    exp_t e;
    e.res = res; e.cnt = cnt; e.err = err;
    q.push_back(e);
  endtask

  initial begin
    exp_t         e;
    logic [127:0] t;
    logic [99:0]  r;

    // AND pass / fail
    t = put(put('0, 0, 5), 1, 5);
    vecs[0] = '{1'b0, 16'h0003, t, 16'h0003, bit_at(5), 1, 1'b0};
    vecs[1] = '{1'b0, 16'h0003, t, 16'h0001, '0, 0, 1'b0};
    // out-of-range index, enabled vs disabled
    t = put('0, 0, 120);
    vecs[2] = '{1'b1, 16'h0001, t, 16'h0001, '0, 0, 1'b1};
    vecs[3] = '{1'b1, 16'h0000, t, 16'h0001, '0, 0, 1'b0};
    // OR with two slots on one string
    t = put(put(put('0, 0, 7), 1, 7), 2, 9);
    vecs[4] = '{1'b1, 16'h0007, t, 16'h0002, bit_at(7), 1, 1'b0};
    // AND with shared string, last valid index
    t = put(put(put(put('0, 0, 10), 1, 10), 2, 20), 3, 99);
    vecs[5] = '{1'b0, 16'h000F, t, 16'h000D,
                bit_at(20) | bit_at(99), 2, 1'b0};
    // index == STRINGS is an error, valid slot still counts
    t = put(put('0, 0, 100), 1, 0);
    vecs[6] = '{1'b0, 16'h0003, t, 16'h0003, bit_at(0), 1, 1'b1};
    // OR over all 16 slots, odd slots match
    t = '0; r = '0;
    for (int i = 0; i < 16; i++) begin
      t = put(t, i, i * 6);
      if (i % 2 == 1) r[i*6] = 1'b1;
    end
    vecs[7] = '{1'b1, 16'hFFFF, t, 16'hAAAA, r, 8, 1'b0};

    idle_inputs();
    reset = 1;
    step(); step();
    chk("reset valid", 128'(result_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset res", 128'(string_results), 128'(0));
    chk("reset cnt", 128'(match_count), 128'(0));
    chk("reset err", 128'(index_error), 128'(0));
    reset = 0;
    step();

    for (int v = 0; v < 8; v++) begin
      open_window(vecs[v].mode);
      chk($sformatf("vec%0d accum busy", v), 128'(busy), 128'(1));
      drive_beat(1'b1, vecs[v].en, vecs[v].tab, vecs[v].rt);
      push_exp(vecs[v].res, vecs[v].cnt, vecs[v].err);
      step();
      idle_inputs();
      wait_result($sformatf("vec%0d", v), e);
      handshake($sformatf("vec%0d", v));
    end

    // OR across two beats
    open_window(1'b1);
    drive_beat(1'b0, 16'h0001, put('0, 0, 2), 16'h0000);
    step();
    drive_beat(1'b1, 16'h0008, put('0, 3, 2), 16'h0008);
    push_exp(bit_at(2), 1, 1'b0);
    step();
    idle_inputs();
    wait_result("or2beat", e);
    handshake("or2beat");

    // backpressure with a start attempt during REPORT
    open_window(vecs[5].mode);
    drive_beat(1'b1, vecs[5].en, vecs[5].tab, vecs[5].rt);
    push_exp(vecs[5].res, vecs[5].cnt, vecs[5].err);
    step();
    idle_inputs();
    wait_result("bp", e);
    for (int c = 0; c < 5; c++) begin
      start = (c == 1); match_mode = (c == 1);
      step();
      start = 0; match_mode = 0;
      chk($sformatf("bp%0d valid", c), 128'(result_valid), 128'(1));
      chk($sformatf("bp%0d res", c), 128'(string_results), 128'(e.res));
      chk($sformatf("bp%0d cnt", c), 128'(match_count), 128'(e.cnt));
    end
    // start in the handshake cycle must not reopen a window
    start = 1;
    handshake("bp");
    start = 0;

    // restart mid-window; beat coinciding with restart is dropped
    open_window(1'b0);
    drive_beat(1'b0, 16'h0001, put('0, 0, 3), 16'h0001);
    step();
    start = 1; match_mode = 1;
    drive_beat(1'b0, 16'h0001, put('0, 0, 4), 16'h0001);
    step();
    start = 0; match_mode = 0;
    drive_beat(1'b1, 16'h0001, put('0, 0, 8), 16'h0001);
    push_exp(bit_at(8), 1, 1'b0);
    step();
    idle_inputs();
    wait_result("restart", e);
    handshake("restart");

    // reset while the result is pending
    open_window(vecs[6].mode);
    drive_beat(1'b1, vecs[6].en, vecs[6].tab, vecs[6].rt);
    push_exp(vecs[6].res, vecs[6].cnt, vecs[6].err);
    step();
    idle_inputs();
    wait_result("rstrep", e);
    reset = 1;
    step();
    reset = 0;
    chk("rstrep valid", 128'(result_valid), 128'(0));
    chk("rstrep busy", 128'(busy), 128'(0));
    chk("rstrep res", 128'(string_results), 128'(0));
    chk("rstrep cnt", 128'(match_count), 128'(0));
    chk("rstrep err", 128'(index_error), 128'(0));

    chk("scoreboard empty", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
